// File: rtl/alu_seq.sv
// Multi-cycle WIDTH-bit ALU with valid/ready handshakes; shifts iterate one bit per cycle.
// Optional zero/overflow flags are enabled by defining ALU_SEQ_FLAGS_EN.
module alu_seq #(
    parameter  int WIDTH = 8,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [SHW-1:0]   in_sh,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_res,
    output logic             out_zero,
    output logic             out_ovf
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [2:0] OP_SRA = 3'b000;
    localparam logic [2:0] OP_SRL = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_ADD = 3'b011;
    localparam logic [2:0] OP_SLL = 3'b100;
    localparam logic [2:0] OP_AND = 3'b101;
    localparam logic [2:0] OP_OR  = 3'b110;
    localparam logic [2:0] OP_XOR = 3'b111;

    logic [1:0]       r_state;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_work;
    logic [SHW-1:0]   r_cnt;
    logic [WIDTH-1:0] r_res;

    logic             w_is_shift;
    logic             w_accept;
    logic             w_iter;
    logic             w_last;
    logic [WIDTH-1:0] w_calc;
    logic [WIDTH-1:0] w_step;

    assign w_is_shift = (in_op == OP_SRA) || (in_op == OP_SRL)
                     || (in_op == OP_SLL);
    assign w_accept   = (r_state == S_IDLE) && in_valid;
    assign w_iter     = w_is_shift && (in_sh != '0);
    assign w_last     = (r_state == S_SHIFT) && (r_cnt == SHW'(1));

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign out_res   = r_res;

    // Single-cycle result; a shift only lands here with a zero amount.
    always_comb begin
        w_calc = in_a;
        unique case (in_op)
            OP_SUB:  w_calc = in_a - in_b;
            OP_ADD:  w_calc = in_a + in_b;
            OP_AND:  w_calc = in_a & in_b;
            OP_OR:   w_calc = in_a | in_b;
            OP_XOR:  w_calc = in_a ^ in_b;
            default: w_calc = in_a;
        endcase
    end

    always_comb begin
        w_step = r_work;
        unique case (r_op)
            OP_SRA:  w_step = {r_work[WIDTH-1], r_work[WIDTH-1:1]};
            OP_SRL:  w_step = {1'b0, r_work[WIDTH-1:1]};
            OP_SLL:  w_step = {r_work[WIDTH-2:0], 1'b0};
            default: w_step = r_work;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_op    <= '0;
            r_work  <= '0;
            r_cnt   <= '0;
            r_res   <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_op <= in_op;
                        if (w_iter) begin
                            r_work  <= in_a;
                            r_cnt   <= in_sh;
                            r_state <= S_SHIFT;
                        end else begin
                            r_res   <= w_calc;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_SHIFT: begin
                    r_work <= w_step;
                    r_cnt  <= r_cnt - SHW'(1);
                    if (r_cnt == SHW'(1)) begin
                        r_res   <= w_step;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef ALU_SEQ_FLAGS_EN
    logic r_zero;
    logic r_ovf;
    logic w_calc_ovf;
    logic w_sa;
    logic w_sb;
    logic w_sr;

    assign w_sa = in_a[WIDTH-1];
    assign w_sb = in_b[WIDTH-1];
    assign w_sr = w_calc[WIDTH-1];

    always_comb begin
        w_calc_ovf = 1'b0;
        unique case (in_op)
            OP_ADD:  w_calc_ovf = (w_sa == w_sb) && (w_sr != w_sa);
            OP_SUB:  w_calc_ovf = (w_sa != w_sb) && (w_sr != w_sa);
            default: w_calc_ovf = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_zero <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (w_accept && !w_iter) begin
            r_zero <= (w_calc == '0);
            r_ovf  <= w_calc_ovf;
        end else if (w_last) begin
            r_zero <= (w_step == '0);
            r_ovf  <= 1'b0;
        end
    end

    assign out_zero = r_zero;
    assign out_ovf  = r_ovf;
`else
    logic w_unused;
    assign w_unused = w_accept ^ w_last;
    assign out_zero = 1'b0;
    assign out_ovf  = 1'b0;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed and random ops checked
// against a plain arithmetic reference model.
module tb_alu_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic [2:0]   in_sh;
    logic [2:0]   in_op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_res;
    logic         out_zero;
    logic         out_ovf;

    int errors = 0;
    int checks = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sh     (in_sh),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_zero  (out_zero),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_shift(input logic [2:0] op);
        return op == 3'b000 || op == 3'b001 || op == 3'b100;
    endfunction

    // Reference: signed integer arithmetic, range check for overflow.
    task automatic model(input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input int sh,
                         output logic [W-1:0] res, output bit z,
                         output bit o);
        int sa, sb, full;
        logic signed [W-1:0] a_s;
        sa = int'($signed(a));
        sb = int'($signed(b));
        a_s = a;
        full = 0;
        case (op)
            3'b000: res = W'(a_s >>> sh);
            3'b001: res = a >> sh;
            3'b010: begin full = sa - sb; res = W'(full); end
            3'b011: begin full = sa + sb; res = W'(full); end
            3'b100: res = a << sh;
            3'b101: res = a & b;
            3'b110: res = a | b;
            default: res = a ^ b;
        endcase
        o = (op == 3'b010 || op == 3'b011) && (full > 127 || full < -128);
        z = (res == 0);
`ifndef ALU_SEQ_FLAGS_EN
        o = 1'b0;
        z = 1'b0;
`endif
    endtask

    task automatic run(input string tag, input logic [2:0] op,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input int sh, input int hold);
        logic [W-1:0] er;
        bit ez, eo;
        int lat, elat;
        model(op, a, b, sh, er, ez, eo);
        elat = (is_shift(op) && sh != 0) ? sh + 1 : 1;
        chk({tag, ".in_ready"}, int'(in_ready), 1);
        in_op = op; in_a = a; in_b = b; in_sh = 3'(sh);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, ".latency"}, lat, elat);
        chk({tag, ".res"}, int'(out_res), int'(er));
        chk({tag, ".zero"}, int'(out_zero), int'(ez));
        chk({tag, ".ovf"}, int'(out_ovf), int'(eo));
        for (int k = 0; k < hold; k++) begin
            in_valid = 1'b1;
            in_op = 3'($urandom); in_a = W'($urandom);
            in_b = W'($urandom); in_sh = 3'($urandom);
            @(posedge clk); #1;
            in_valid = 1'b0;
            chk({tag, ".hold_valid"}, int'(out_valid), 1);
            chk({tag, ".hold_ready"}, int'(in_ready), 0);
            chk({tag, ".hold_res"}, int'(out_res), int'(er));
            chk({tag, ".hold_flags"}, int'({out_zero, out_ovf}),
                int'({ez, eo}));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, ".post_valid"}, int'(out_valid), 0);
        chk({tag, ".post_ready"}, int'(in_ready), 1);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_sh = '0; in_op = '0;
        #1;
        chk("rst.in_ready", int'(in_ready), 1);
        chk("rst.out_valid", int'(out_valid), 0);
        chk("rst.out_res", int'(out_res), 0);
        chk("rst.flags", int'({out_zero, out_ovf}), 0);
        #21 rst_n = 1'b1;
        @(posedge clk); #1;

        run("sra", 3'b000, 8'hA4, 8'h00, 2, 0);
        run("srl", 3'b001, 8'hA4, 8'h00, 2, 0);
        run("sll7", 3'b100, 8'hA4, 8'h00, 7, 0);
        run("sub", 3'b010, 8'h80, 8'h01, 0, 0);
        run("add_ovf", 3'b011, 8'h7F, 8'h01, 0, 0);
        run("add_zero", 3'b011, 8'hFF, 8'h01, 0, 0);
        run("sra0", 3'b000, 8'h81, 8'h00, 0, 0);
        run("backpr", 3'b111, 8'h5A, 8'h0F, 0, 5);
        run("sra7", 3'b000, 8'h80, 8'h00, 7, 1);

        for (int i = 0; i < 40; i++)
            run("rand", 3'($urandom), W'($urandom), W'($urandom),
                int'($urandom_range(0, 7)), int'($urandom_range(0, 2)));

        in_op = 3'b001; in_a = 8'hF0; in_sh = 3'd6; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("midrst.in_ready", int'(in_ready), 1);
        chk("midrst.out_valid", int'(out_valid), 0);
        chk("midrst.out_res", int'(out_res), 0);
        chk("midrst.flags", int'({out_zero, out_ovf}), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run("postrst", 3'b011, 8'h03, 8'h04, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
